pipe_adder: RTL and testbench
=============================

// Module: pipe_adder
// PURPOSE
//  Parametrised, pipelined WIDTH-bit add/subtract unit. It is the successor to our
//  4-bit ripple-carry cell and targets 64-bit operands at clock rate.
//  Operands are split into CHUNK-bit slices; one slice resolves per pipeline stage,
//  and the carry is registered between stages.
//  Valid/ready handshakes on both sides; sits between operand sources and the ALU result bus.
// PARAMETERS
//  WIDTH  64  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK  16  bits resolved per stage; STAGES = WIDTH/CHUNK (localparam, >=1)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair present
//  in_ready   out  1      unit accepts operands this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      1: A-B, 0: A+B
//  out_valid  out  1      result present
//  out_ready  in   1      consumer takes result this cycle
//  out_sum    out  WIDTH  result, modulo 2^WIDTH
//  out_cout   out  1      carry out of MSB; for subtract = NOT borrow (1 when A>=B unsigned)
//  out_ovf    out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): every stage valid=0, all data regs=0;
//    out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1 after reset.
//  - Transfer occurs on a cycle where valid&&ready; in_ready has no dependence on in_valid.
//  - Stage 0 input: b' = in_sub ? ~in_b : in_b, c0 = in_sub. Slice k (k=0..STAGES-1) is
//    sum[k*CHUNK +: CHUNK] = a_k + b'_k + c_k (ripple), c_{k+1} = slice carry out.
//  - Stage k register holds: valid, resolved low slices 0..k, unresolved upper A/B' slices,
//    carry c_{k+1}. Stage STAGES-1 is the output register.
//  - out_ovf = c_WIDTH XOR c_{WIDTH-1} (carry into vs. out of MSB), computed in the last slice.
//  - Latency: an operand accepted in cycle t has out_valid=1 in cycle t+STAGES-1 after the edge,
//    i.e. it is visible STAGES clock edges after acceptance (STAGES=1 -> next cycle).
//  - Advance rule: adv[S-1] = v[S-1] && out_ready. For k<S-1, adv[k] = v[k] && (!v[k+1] || adv[k+1]).
//    in_ready = !v[0] || adv[0]. Bubbles collapse; a full pipe with out_ready=1 sustains 1 op/cycle.
//  - Backpressure: with out_ready=0, the pipe fills with STAGES ops and then in_ready=0.
//    Held data is stable, and no op is lost, duplicated or reordered.
//  - out_* are driven directly from the last-stage register (no comb path from in_*).
//  - Simultaneous fill and drain in the same stage (adv out and in the same edge) is legal.
//    The stage takes the new op and stays valid.
//  - Reset mid-operation discards every in-flight op; the first op after reset obeys the latency above.
// STRUCTURE
//  - pipe_adder_pkg: typedef of the stage record, a function computing STAGES, and an
//    elaboration check that WIDTH%CHUNK==0 and CHUNK>=1.
//  - Sub-module adder_chunk #(CHUNK): combinational ripple slice (a, b, cin -> sum, cout,
//    c_msb_in for overflow); one instance per stage via generate.
// TESTING  (WIDTH=64, CHUNK=16 unless noted)
//  1. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> sum 0x0, cout 1, ovf 0, out_valid exactly 4 edges
//     after accept (carry ripples across all slices).
//  2. Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> sum 0x8000_0000_0000_0000, cout 0, ovf 1.
//  3. Sub 0x0 - 0x1 -> sum 0xFFFF_FFFF_FFFF_FFFF, cout 0, ovf 0.
//     Sub 0x5 - 0x5 -> sum 0, cout 1, ovf 0.
//  4. 100 back-to-back random ops, out_ready=1 -> one result/cycle, in order, matching the model.
//  5. Hold out_ready=0 for 10 cycles while streaming -> in_ready falls after 4 accepts,
//     out_* stable. Release -> all ops drain in order.
//  6. Assert rst_n=0 with 3 ops in flight -> out_valid=0 and outputs 0 immediately.
//     After release, a new op 2+3 -> 5 with full latency. Repeat 1-3 with WIDTH=8, CHUNK=8 (STAGES=1).

Source files
------------

// File: rtl/pipe_adder_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_adder_pkg : stage record type and elaboration helpers
// Rev 1.0
// ------------------------------------------------------------------
package pipe_adder_pkg;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctrl_t;

    function automatic int unsigned num_stages(input int unsigned width, input int unsigned chunk);
        if (chunk == 0 || width < chunk) return 1;
        return width / chunk;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_chunk.sv
`default_nettype none
// ------------------------------------------------------------------
// adder_chunk : combinational CHUNK-bit ripple slice with MSB carry tap
// Rev 1.0
// ------------------------------------------------------------------
module adder_chunk
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    if (CHUNK == 1) begin : g_single
        assign c_msb_o         = cin_i;
        assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {1'b0, cin_i};
    end else begin : g_multi
        // Split off the MSB so the carry into it is visible for overflow.
        logic [CHUNK-1:0] w_low;
        logic [1:0]       w_top;

        assign w_low   = {1'b0, a_i[CHUNK-2:0]} + {1'b0, b_i[CHUNK-2:0]}
                       + {{(CHUNK-1){1'b0}}, cin_i};
        assign c_msb_o = w_low[CHUNK-1];
        assign w_top   = {1'b0, a_i[CHUNK-1]} + {1'b0, b_i[CHUNK-1]} + {1'b0, c_msb_o};
        assign sum_o   = {w_top[0], w_low[CHUNK-2:0]};
        assign cout_o  = w_top[1];
    end

endmodule
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_adder : pipelined WIDTH-bit add/subtract, one CHUNK slice per stage
// Rev 1.0
// ------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = int'(num_stages(WIDTH, CHUNK));

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("pipe_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Operands/partial sums entering each stage, kept at their natural bit positions.
    logic [WIDTH-1:0]  w_a   [STAGES];
    logic [WIDTH-1:0]  w_b   [STAGES];
    logic [WIDTH-1:0]  w_sum [STAGES];
    logic [STAGES-1:0] w_c;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    assign w_a[0]   = in_a;
    assign w_b[0]   = in_sub ? ~in_b : in_b;
    assign w_c[0]   = in_sub;
    assign w_sum[0] = '0;

    always_comb begin
        w_adv              = '0;
        w_adv[STAGES-1]    = w_v[STAGES-1] && out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = w_v[k] && (!w_v[k+1] || w_adv[k+1]);
        end
    end

    assign in_ready = !w_v[0] || w_adv[0];

    always_comb begin
        w_load    = '0;
        w_load[0] = in_valid && in_ready;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_slice;
        logic             w_cout;
        logic             w_cmsb;
        logic [WIDTH-1:0] w_sum_d;
        stage_ctrl_t      ctrl_q;
        logic [WIDTH-1:0] sum_q;

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_i     (w_a[k][k*CHUNK +: CHUNK]),
            .b_i     (w_b[k][k*CHUNK +: CHUNK]),
            .cin_i   (w_c[k]),
            .sum_o   (w_slice),
            .cout_o  (w_cout),
            .c_msb_o (w_cmsb)
        );

        always_comb begin
            w_sum_d                    = w_sum[k];
            w_sum_d[k*CHUNK +: CHUNK]  = w_slice;
        end

        // A load wins over a drain on the same edge, so fill-while-draining keeps valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_q <= '0;
                sum_q  <= '0;
            end else if (w_load[k]) begin
                ctrl_q.valid <= 1'b1;
                ctrl_q.carry <= w_cout;
                sum_q        <= w_sum_d;
            end else if (w_adv[k]) begin
                ctrl_q.valid <= 1'b0;
            end
        end

        assign w_v[k] = ctrl_q.valid;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic             w_unused_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (w_load[k]) begin
                    a_q <= w_a[k];
                    b_q <= w_b[k];
                end
            end

            assign w_a[k+1]      = a_q;
            assign w_b[k+1]      = b_q;
            assign w_c[k+1]      = ctrl_q.carry;
            assign w_sum[k+1]    = sum_q;
            assign w_unused_cmsb = w_cmsb;
        end else begin : g_out
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (w_load[k]) begin
                    ovf_q <= w_cout ^ w_cmsb;
                end
            end

            assign out_valid = ctrl_q.valid;
            assign out_sum   = sum_q;
            assign out_cout  = ctrl_q.carry;
            assign out_ovf   = ovf_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipe_adder : scoreboard bench for pipe_adder (64/16 and 8/8)
// Rev 1.0
// ------------------------------------------------------------------
module tb_pipe_adder;

    localparam int STAGES = 4;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready, out_cout, out_ovf;
    logic [63:0] in_a, in_b, out_sum;
    logic        s_in_valid, s_in_ready, s_in_sub, s_out_valid, s_out_ready, s_out_cout, s_out_ovf;
    logic [7:0]  s_in_a, s_in_b, s_out_sum;

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    bit   chk_lat = 1'b1;
    exp_t sb[$];

    pipe_adder #(.WIDTH(64), .CHUNK(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    pipe_adder #(.WIDTH(8), .CHUNK(8)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_sub(s_in_sub), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_sum(s_out_sum), .out_cout(s_out_cout), .out_ovf(s_out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        exp_t        e;
        logic [64:0] full;
        logic [63:0] bb;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {64'd0, sub};
        e.sum  = full[63:0];
        e.cout = full[64];
        if (sub) e.ovf = (a[63] != b[63]) && (e.sum[63] != a[63]);
        else     e.ovf = (a[63] == b[63]) && (e.sum[63] != a[63]);
        e.cyc  = 0;
        return e;
    endfunction

    // Scoreboard: push on accept, pop on result transfer; both seen mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e     = model(in_a, in_b, in_sub);
            e.cyc = cyc;
            sb.push_back(e);
        end
        if (rst_n && out_valid && out_ready) begin
            n_total++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected got sum=%h with no op pending", out_sum);
            end else begin
                e = sb.pop_front();
                if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf) begin
                    n_bad++;
                    $display("FAIL result got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
                             out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
                end
                if (chk_lat) begin
                    n_total++;
                    if (cyc - e.cyc != STAGES) begin
                        n_bad++;
                        $display("FAIL latency got=%0d want=%0d", cyc - e.cyc, STAGES);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_total++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_out got v=%b sum=%h c=%b o=%b want all 0", out_valid, out_sum, out_cout, out_ovf);
        end
        n_total++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        n_total++;
        if (s_out_valid !== 1'b0 || s_out_sum !== 8'd0 || s_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_small got v=%b sum=%h rdy=%b want 0/00/1", s_out_valid, s_out_sum, s_in_ready);
        end
    endtask

    task automatic test_directed(input logic [63:0] a, input logic [63:0] b, input logic sub, input string name);
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        n_total++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_ready got=%b want=1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout got pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_a     = {$urandom(), $urandom()};
            in_b     = {$urandom(), $urandom()};
            in_sub   = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            if (in_ready !== 1'b1) stalls++;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
        n_total++;
        if (stalls != 0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL b2b got stalls=%0d pending=%0d want 0/0", stalls, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        int          acc    = 0;
        bit          seen   = 1'b0;
        bit          moved  = 1'b0;
        logic [63:0] held   = '0;
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = {$urandom(), $urandom()}; in_b = {$urandom(), $urandom()}; in_sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit took;
            took = in_ready;
            tick();
            if (took) begin
                acc++;
                in_a   = {$urandom(), $urandom()};
                in_b   = {$urandom(), $urandom()};
                in_sub = 1'($urandom_range(0, 1));
            end
            if (out_valid && seen && out_sum !== held) moved = 1'b1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                held = out_sum;
            end
        end
        n_total++;
        if (acc != STAGES || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_fill got accepts=%0d in_ready=%b want %0d/0", acc, in_ready, STAGES);
        end
        n_total++;
        if (!seen || moved) begin
            n_bad++;
            $display("FAIL bp_hold got seen=%b moved=%b want 1/0", seen, moved);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        n_total++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL bp_drain got pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a = 64'(i + 10); in_b = 64'(i + 20); in_sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        n_total++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre got out_valid=%b want=1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_sum !== 64'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid got v=%b sum=%h c=%b o=%b want all 0", out_valid, out_sum, out_cout, out_ovf);
        end
        sb.delete();
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();
        test_directed(64'd2, 64'd3, 1'b0, "post_rst");
    endtask

    task automatic test_small();
        logic [7:0] av[4] = '{8'hFF, 8'h7F, 8'h00, 8'h05};
        logic [7:0] bv[4] = '{8'h01, 8'h01, 8'h01, 8'h05};
        logic       sv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] es[4] = '{8'h00, 8'h80, 8'hFF, 8'h00};
        logic       ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       eo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_a = av[i]; s_in_b = bv[i]; s_in_sub = sv[i]; s_in_valid = 1'b1;
            n_total++;
            if (s_in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL small%0d_ready got=%b want=1", i, s_in_ready);
            end
            tick();
            s_in_valid = 1'b0;
            n_total++;
            if (s_out_valid !== 1'b1 || s_out_sum !== es[i] || s_out_cout !== ec[i] || s_out_ovf !== eo[i]) begin
                n_bad++;
                $display("FAIL small%0d got v=%b sum=%h c=%b o=%b want 1 %h %b %b",
                         i, s_out_valid, s_out_sum, s_out_cout, s_out_ovf, es[i], ec[i], eo[i]);
            end
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_sub = 1'b0; s_out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_directed(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "add_wrap");
        test_directed(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "add_ovf");
        test_directed(64'h0, 64'h1, 1'b1, "sub_borrow");
        test_directed(64'h5, 64'h5, 1'b1, "sub_equal");
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
